// File: rtl/pa_pipe_pkg.sv
// Shared pipeline definitions for the PA-RISC front end.
//   NOP_WORD      : bubble word written into pipeline registers on reset/squash
//   PC_STEP       : sequential program-counter increment in bytes
//   IFID_*_W      : IF/ID field widths
//   word_align()  : clears the two byte-offset bits of an address
package pa_pipe_pkg;

    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam int          IFID_INSTR_W = 32;
    localparam int          IFID_PC_W    = 32;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pa_fetch_unit_if.sv
// Bus bundle between the fetch unit and its surroundings (hazard unit,
// branch resolution, instruction memory, decode stage, debug monitor).
//   master : the fetch unit side (drives imem_addr, PC/IF-ID outputs, misalign_err)
//   slave  : the environment side (drives stall, redirect, nullify, imem_rdata)
interface pa_fetch_unit_if
    import pa_pipe_pkg::*;
#(
    parameter int IMEM_AW = 9
);
    logic                    stall;
    logic                    branch_taken;
    logic [31:0]             branch_target;
    logic                    nullify;
    logic [IMEM_AW-1:0]      imem_addr;
    logic [31:0]             imem_rdata;
    logic [31:0]             pc_front_out;
    logic [31:0]             pc_rear_out;
    logic [IFID_INSTR_W-1:0] ifid_instr;
    logic [IFID_PC_W-1:0]    ifid_pc;
    logic                    ifid_valid;
    logic                    misalign_err;

    modport master (
        input  stall, branch_taken, branch_target, nullify, imem_rdata,
        output imem_addr, pc_front_out, pc_rear_out,
               ifid_instr, ifid_pc, ifid_valid, misalign_err
    );

    modport slave (
        output stall, branch_taken, branch_target, nullify, imem_rdata,
        input  imem_addr, pc_front_out, pc_rear_out,
               ifid_instr, ifid_pc, ifid_valid, misalign_err
    );

endinterface

// File: rtl/pa_ifid_reg.sv
// Generic pipeline register with hold and squash.
//   clk, rst_n : clock, async active-low reset (clears to BUBBLE / 0 / invalid)
//   en_i       : load enable; low holds the current contents
//   squash_i   : when loading, insert BUBBLE with valid=0 instead of instr_i
//   instr_i/pc_i          : incoming instruction and its address
//   instr_o/pc_o/valid_o  : registered outputs
module pa_ifid_reg
    import pa_pipe_pkg::*;
#(
    parameter int                 INSTR_W = IFID_INSTR_W,
    parameter int                 PC_W    = IFID_PC_W,
    parameter logic [INSTR_W-1:0] BUBBLE  = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               squash_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               valid_q, valid_d;

    // Squash only matters on a load; while held the register keeps whatever
    // it already has.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (en_i) begin
            instr_d = squash_i ? BUBBLE : instr_i;
            pc_d    = pc_i;
            valid_d = ~squash_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= BUBBLE;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pa_fetch_unit.sv
// PA-RISC instruction-fetch stage with front/rear PC pair (delayed branching).
//   clk   : system clock
//   reset : async active-low reset
//   bus   : pa_fetch_unit_if.master
//           stall/branch_taken/branch_target/nullify in, imem_rdata in,
//           imem_addr, pc_front_out, pc_rear_out, ifid_* and misalign_err out
// A redirect lands in pc_rear, so the instruction already at pc_rear (the
// delay slot) is always fetched before the target. Redirects seen during a
// stall are parked in a pending register and applied on the first free cycle.
module pa_fetch_unit
    import pa_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 9,
    parameter logic [31:0] NOP_WORD = pa_pipe_pkg::NOP_WORD
) (
    input  logic             clk,
    input  logic             reset,
    pa_fetch_unit_if.master  bus
);

    logic [31:0] pc_front_q, pc_front_d;
    logic [31:0] pc_rear_q, pc_rear_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        misalign_q, misalign_d;

    logic        redir;
    logic [31:0] tgt_raw;

    // A live pulse wins over a parked one.
    assign redir   = bus.branch_taken | pend_valid_q;
    assign tgt_raw = bus.branch_taken ? bus.branch_target : pend_target_q;

    always_comb begin
        pc_front_d    = pc_front_q;
        pc_rear_d     = pc_rear_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        misalign_d    = misalign_q;
        if (!bus.stall) begin
            pc_front_d   = pc_rear_q;
            pc_rear_d    = redir ? word_align(tgt_raw) : pc_rear_q + PC_STEP;
            pend_valid_d = 1'b0;
            if (redir && (tgt_raw[1:0] != 2'b00)) begin
                misalign_d = 1'b1;
            end
        end else if (bus.branch_taken) begin
            pend_valid_d  = 1'b1;
            pend_target_d = bus.branch_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_front_q    <= RESET_PC;
            pc_rear_q     <= RESET_PC + PC_STEP;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            misalign_q    <= 1'b0;
        end else begin
            pc_front_q    <= pc_front_d;
            pc_rear_q     <= pc_rear_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            misalign_q    <= misalign_d;
        end
    end

    pa_ifid_reg #(
        .INSTR_W (IFID_INSTR_W),
        .PC_W    (IFID_PC_W),
        .BUBBLE  (NOP_WORD)
    ) u_ifid (
        .clk      (clk),
        .rst_n    (reset),
        .en_i     (~bus.stall),
        .squash_i (bus.nullify),
        .instr_i  (bus.imem_rdata),
        .pc_i     (pc_front_q),
        .instr_o  (bus.ifid_instr),
        .pc_o     (bus.ifid_pc),
        .valid_o  (bus.ifid_valid)
    );

    // Address comes straight from a register: no path from stall/redirect.
    assign bus.imem_addr    = pc_front_q[IMEM_AW-1:0];
    assign bus.pc_front_out = pc_front_q;
    assign bus.pc_rear_out  = pc_rear_q;
    assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_pa_fetch_unit.sv
module tb_pa_fetch_unit;

    logic clk;
    logic rst_n;

    pa_fetch_unit_if #(.IMEM_AW(9)) bus ();

    pa_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (9),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 512-byte instruction memory, word addressed by imem_addr[8:2].
    logic [31:0] imem_arr [128];
    assign bus.imem_rdata = imem_arr[bus.imem_addr[8:2]];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Reference model: architectural view of the fetch stage.
    logic [31:0] m_front, m_rear, m_instr, m_ipc, m_pt;
    logic        m_valid, m_pv, m_mis;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [8:0] a9;
        a9 = addr[8:0];
        return imem_arr[a9[8:2]];
    endfunction

    task automatic model_reset();
        m_front = 32'h0;
        m_rear  = 32'h4;
        m_instr = 32'h0;
        m_ipc   = 32'h0;
        m_valid = 1'b0;
        m_pv    = 1'b0;
        m_pt    = 32'h0;
        m_mis   = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic bt,
                              input logic [31:0] tgt, input logic nul);
        logic        go;
        logic [31:0] t;
        if (!st) begin
            go = bt || m_pv;
            t  = bt ? tgt : m_pt;
            if (go && (t[1:0] != 2'b00)) m_mis = 1'b1;
            m_instr = nul ? 32'h0 : mem_word(m_front);
            m_ipc   = m_front;
            m_valid = !nul;
            m_front = m_rear;
            m_rear  = go ? (t & 32'hFFFF_FFFC) : (m_rear + 32'd4);
            m_pv    = 1'b0;
        end else if (bt) begin
            m_pv = 1'b1;
            m_pt = tgt;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pc_front",  bus.pc_front_out,          m_front);
        chk("pc_rear",   bus.pc_rear_out,           m_rear);
        chk("imem_addr", {23'b0, bus.imem_addr},    {23'b0, m_front[8:0]});
        chk("ifid_instr", bus.ifid_instr,           m_instr);
        chk("ifid_pc",   bus.ifid_pc,               m_ipc);
        chk("ifid_valid", {31'b0, bus.ifid_valid},  {31'b0, m_valid});
        chk("misalign",  {31'b0, bus.misalign_err}, {31'b0, m_mis});
    endtask

    // Called at a negedge: drive inputs, advance one rising edge, check.
    task automatic cycle(input logic st, input logic bt,
                         input logic [31:0] tgt, input logic nul);
        bus.stall         = st;
        bus.branch_taken  = bt;
        bus.branch_target = tgt;
        bus.nullify       = nul;
        model_step(st, bt, tgt, nul);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        bus.nullify      = 1'b0;
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) imem_arr[i] = $urandom;
        rst_n             = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        bus.nullify       = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // sequential fetch after reset release
        cycle(0, 0, 32'h0, 0);
        cycle(0, 0, 32'h0, 0);
        // branch to 0x40 with front=8 rear=12
        cycle(0, 1, 32'h40, 0);
        cycle(0, 0, 32'h0, 0);
        cycle(0, 0, 32'h0, 0);
        cycle(0, 0, 32'h0, 0);
        // branch followed by nullified delay slot
        cycle(0, 1, 32'h100, 0);
        cycle(0, 0, 32'h0, 1);
        cycle(0, 0, 32'h0, 0);
        cycle(0, 0, 32'h0, 0);
        // three-cycle stall, redirect in the middle, nullify ignored while stalled
        cycle(1, 0, 32'h0, 1);
        cycle(1, 1, 32'h80, 0);
        cycle(1, 0, 32'h0, 0);
        cycle(0, 0, 32'h0, 0);
        cycle(0, 0, 32'h0, 0);
        cycle(0, 0, 32'h0, 0);
        // last pending pulse wins; live pulse overrides pending
        cycle(1, 1, 32'h120, 0);
        cycle(1, 1, 32'h130, 0);
        cycle(0, 0, 32'h0, 0);
        cycle(0, 0, 32'h0, 0);
        cycle(1, 1, 32'h150, 0);
        cycle(0, 1, 32'h160, 0);
        cycle(0, 0, 32'h0, 0);
        cycle(0, 0, 32'h0, 0);
        // PC wraps modulo 2^32
        cycle(0, 1, 32'hFFFF_FFF8, 0);
        repeat (4) cycle(0, 0, 32'h0, 0);
        // misaligned target: sticky flag, fetch from aligned address
        cycle(0, 1, 32'h42, 0);
        repeat (3) cycle(0, 0, 32'h0, 0);

        // asynchronous reset mid-run, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        cycle(0, 0, 32'h0, 0);
        cycle(0, 0, 32'h0, 0);

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            logic        st, bt, nul;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 3) == 0);
            bt  = ($urandom_range(0, 5) == 0);
            nul = ($urandom_range(0, 4) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt = tgt & 32'h0000_01FC;
            cycle(st, bt, tgt, nul);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pa_fetch_unit.md
Name: pa_fetch_unit

Overview:
- Instruction-fetch stage of the 32-bit PA-RISC pipeline. Sits directly upstream of the decode stage inside PA_RISC.
- Owns the front/rear program-counter pair that implements PA-RISC delayed branching.
- Drives the instruction-memory address and registers the fetched word into the IF/ID pipeline register.
- Handles stall, branch redirect (including a redirect that arrives while stalled), and delay-slot nullification.

Parameters:
- RESET_PC, 32'h0000_0000, pc_front value after reset.
- IMEM_AW, 9, instruction-memory byte-address width.
- NOP_WORD, 32'h0000_0000, word inserted into IF/ID on reset or nullify.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hazard-unit hold; freezes PCs and IF/ID.
- branch_taken  input  1  redirect request from ID/EX, one-cycle pulse.
- branch_target  input  32  redirect byte address.
- nullify  input  1  squash the instruction entering IF/ID this cycle.
- imem_addr  output  IMEM_AW  byte address to instruction memory, equal to pc_front[IMEM_AW-1:0].
- imem_rdata  input  32  combinational instruction-memory read data.
- pc_front_out  output  32  current pc_front, for debug/monitor.
- pc_rear_out  output  32  current pc_rear.
- ifid_instr  output  32  registered instruction.
- ifid_pc  output  32  registered address of ifid_instr.
- ifid_valid  output  1  ifid_instr is a real, non-squashed instruction.
- misalign_err  output  1  sticky flag: a branch target with bits[1:0] != 0 was seen.

Behaviour:
- Reset (reset==0, asynchronous):
  - pc_front=RESET_PC, pc_rear=RESET_PC+4.
  - ifid_instr=NOP_WORD, ifid_pc=0, ifid_valid=0.
  - pend_valid=0, pend_target=0, misalign_err=0.
  - Reset deassertion is sampled; the first fetch happens on the first rising edge with reset==1.
- Effective redirect this cycle:
  - redir = branch_taken | pend_valid.
  - tgt = branch_taken ? branch_target : pend_target. A live request overrides a pending one.
  - tgt[1:0] is forced to 2'b00.
- Normal cycle (stall==0):
  - pc_front <= pc_rear.
  - pc_rear <= redir ? tgt : pc_rear + 4.
  - Consequence: the instruction at the old pc_rear (the delay slot) is always fetched after a taken branch.
  - The target is fetched one cycle after the delay slot.
  - IF/ID <= {imem_rdata, pc_front, 1}.
  - pend_valid <= 0.
- Stall cycle (stall==1):
  - pc_front, pc_rear and IF/ID all hold.
  - If branch_taken is 1: pend_valid <= 1 and pend_target <= branch_target. A later pulse overwrites an earlier one (last wins).
  - The redirect is applied on the first non-stall cycle.
- Nullify (stall==0, nullify==1):
  - PCs update as in a normal cycle.
  - IF/ID <= {NOP_WORD, pc_front, 0}, squashing the delay slot.
  - nullify during stall is ignored.
- misalign_err: set when a redirect is accepted with tgt bits[1:0] != 0; cleared only by reset.
- Arithmetic: PC increment is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. imem_addr truncates the upper bits.
- Latency: one cycle from imem_rdata to ifid_instr.
- No combinational path from stall, branch_taken or nullify to imem_addr. imem_addr depends on pc_front only.

Decomposition:
- Shared package pa_pipe_pkg holds:
  - localparams NOP_WORD and PC_STEP=4.
  - IF/ID field widths.
- One natural sub-module, pa_ifid_reg: the IF/ID register with enable (~stall) and squash (nullify); it is also reused for later pipeline registers.
- PC pair, pending-redirect register and misalign flag live in pa_fetch_unit. Target size about 150–200 lines.

Test Plan:
- Reset release, imem returns word = address: expect pc_front_out 0,4,8,12 on successive edges. ifid_pc trails pc_front_out by one cycle; ifid_valid rises on the first edge.
- branch_taken pulse with target 0x40 while pc_front=8, pc_rear=12: expect ifid_pc sequence 8,12,0x40,0x44. 12 is the delay slot.
- Same as the previous case with nullify high in the cycle after the branch: the IF/ID entry for 12 has ifid_valid=0 and ifid_instr=0; the next entry is 0x40 with valid=1.
- stall held 3 cycles, branch_taken 0x80 pulsed in stall cycle 2:
  - PCs and IF/ID hold for all 3 cycles.
  - After release, the fetch order is the delay slot, then 0x80.
  - pend_valid clears after the release edge.
- Branch target 0x42: expect misalign_err=1 (sticky) and a fetch from 0x40. Mid-run reset assertion clears misalign_err and returns pc_front_out to 0 asynchronously without waiting for clk.
